// File: rtl/pong_pkg.sv
// pong_pkg: shared types and default geometry for the Pong ball logic.
// Coordinates are 10-bit unsigned on ports; arithmetic is done in 11-bit
// signed so that a step past an edge is seen as negative or oversized
// instead of wrapping.
package pong_pkg;

    localparam int COORD_W = 10;
    localparam int POS_W   = COORD_W + 1;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_BALL        = 8;
    localparam int DEF_PADDLE_H    = 64;
    localparam int DEF_PADDLE_FACE = 24;
    localparam int DEF_WIN_SCORE   = 9;
    localparam int DEF_SCORE_HOLD  = 500;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SCORED = 2'd2,
        ST_OVER   = 2'd3
    } ball_state_e;

    function automatic logic signed [POS_W-1:0] to_pos(input logic [COORD_W-1:0] v);
        return $signed({1'b0, v});
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// tick_edge_detect: brings the 1 kHz tick into clk_in and turns each rising
// edge into a one-cycle step pulse, three clk_in cycles after the rise.
// A valid pipeline follows the data through the flops so that a tick that is
// already high when reset releases is not mistaken for a fresh rise.
module tick_edge_detect (
    input  logic clk_in,
    input  logic rst_n,
    input  logic tick_in,
    output logic step
);

    logic       sync_1;
    logic       sync_2;
    logic       tick_prev;
    logic [2:0] vld_pipe;

    // Two-flop synchronizer, history flop and registered rising-edge pulse.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            tick_prev <= 1'b0;
            vld_pipe  <= 3'b000;
            step      <= 1'b0;
        end else begin
            sync_1    <= tick_in;
            sync_2    <= sync_1;
            tick_prev <= sync_2;
            vld_pipe  <= {vld_pipe[1:0], 1'b1};
            step      <= sync_2 & ~tick_prev & vld_pipe[2];
        end
    end

endmodule

// File: rtl/ball_controller.sv
// ball_controller: ball motion, wall/paddle bounces, scoring and serve flow.
// Build option: define BALL_SPEEDUP_EN to make each paddle hit raise the
// speed by one (max 4), reset to 1 on every point. Default: speed fixed at 1.
//
//   state  | meaning
//   IDLE   | ball parked, waiting for serve
//   MOVE   | ball advances one increment per step
//   SCORED | ball recentred, pausing SCORE_HOLD steps before play resumes
//   OVER   | a player reached WIN_SCORE; serve clears scores and goes IDLE
module ball_controller
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int BALL        = DEF_BALL,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int PADDLE_FACE = DEF_PADDLE_FACE,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int SCORE_HOLD  = DEF_SCORE_HOLD
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               tick_in,
    input  logic               serve,
    input  logic [COORD_W-1:0] paddle_l_y,
    input  logic [COORD_W-1:0] paddle_r_y,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [3:0]         score_l,
    output logic [3:0]         score_r,
    output logic               point_l,
    output logic               point_r,
    output logic               game_over
);

    localparam int HOLD_W = (SCORE_HOLD < 2) ? 1 : $clog2(SCORE_HOLD + 1);
    localparam int OVL_W  = COORD_W + 2;

    localparam logic signed [POS_W-1:0] X_MAX  = POS_W'(SCREEN_W - BALL);
    localparam logic signed [POS_W-1:0] Y_MAX  = POS_W'(SCREEN_H - BALL);
    localparam logic signed [POS_W-1:0] FACE_L = POS_W'(PADDLE_FACE);
    localparam logic signed [POS_W-1:0] FACE_R = POS_W'(SCREEN_W - PADDLE_FACE - BALL);
    localparam logic [COORD_W-1:0]      X_CTR  = COORD_W'((SCREEN_W - BALL) / 2);
    localparam logic [COORD_W-1:0]      Y_CTR  = COORD_W'((SCREEN_H - BALL) / 2);
    localparam logic [3:0]              WIN    = 4'(WIN_SCORE);

    ball_state_e         state;
    logic                dx_pos;
    logic                dy_pos;
    logic [2:0]          speed;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                step_pulse;

    logic signed [POS_W-1:0] cur_x;
    logic signed [POS_W-1:0] cur_y;
    logic signed [POS_W-1:0] step_amt;
    logic signed [POS_W-1:0] nx;
    logic signed [POS_W-1:0] ny;
    logic [OVL_W-1:0]        ball_bot;
    logic [OVL_W-1:0]        ball_top;
    logic                    overlap_l;
    logic                    overlap_r;
    logic [COORD_W-1:0]      x_nxt;
    logic [COORD_W-1:0]      y_nxt;
    logic                    dx_nxt;
    logic                    dy_nxt;
    logic                    hit;
    logic                    score_for_l;
    logic                    score_for_r;
    logic [3:0]              score_l_inc;
    logic [3:0]              score_r_inc;

    tick_edge_detect u_tick_edge (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .tick_in (tick_in),
        .step    (step_pulse)
    );

    // Candidate next position; each axis is resolved on its own so corner hits compose.
    always_comb begin
        cur_x     = to_pos(ball_x);
        cur_y     = to_pos(ball_y);
        step_amt  = $signed({{(POS_W-3){1'b0}}, speed});
        nx        = dx_pos ? (cur_x + step_amt) : (cur_x - step_amt);
        ny        = dy_pos ? (cur_y + step_amt) : (cur_y - step_amt);
        ball_top  = {2'b00, ball_y};
        ball_bot  = {2'b00, ball_y} + OVL_W'(BALL);
        overlap_l = (ball_bot > {2'b00, paddle_l_y}) &&
                    (ball_top < ({2'b00, paddle_l_y} + OVL_W'(PADDLE_H)));
        overlap_r = (ball_bot > {2'b00, paddle_r_y}) &&
                    (ball_top < ({2'b00, paddle_r_y} + OVL_W'(PADDLE_H)));

        y_nxt  = ny[COORD_W-1:0];
        dy_nxt = dy_pos;
        if (ny <= 0) begin
            y_nxt  = '0;
            dy_nxt = 1'b1;
        end else if (ny >= Y_MAX) begin
            y_nxt  = Y_MAX[COORD_W-1:0];
            dy_nxt = 1'b0;
        end

        x_nxt       = nx[COORD_W-1:0];
        dx_nxt      = dx_pos;
        hit         = 1'b0;
        score_for_l = 1'b0;
        score_for_r = 1'b0;
        if (!dx_pos && (nx <= FACE_L) && overlap_l) begin
            x_nxt  = FACE_L[COORD_W-1:0];
            dx_nxt = 1'b1;
            hit    = 1'b1;
        end else if (dx_pos && (nx >= FACE_R) && overlap_r) begin
            x_nxt  = FACE_R[COORD_W-1:0];
            dx_nxt = 1'b0;
            hit    = 1'b1;
        end else if (nx <= 0) begin
            score_for_r = 1'b1;
        end else if (nx >= X_MAX) begin
            score_for_l = 1'b1;
        end

        score_l_inc = sat_inc(score_l, WIN);
        score_r_inc = sat_inc(score_r, WIN);
    end

    // Game state machine: serve handling, motion, scoring and the post-point pause.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ball_x   <= X_CTR;
            ball_y   <= Y_CTR;
            dx_pos   <= 1'b1;
            dy_pos   <= 1'b1;
            score_l  <= 4'd0;
            score_r  <= 4'd0;
            point_l  <= 1'b0;
            point_r  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            point_l <= 1'b0;
            point_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (serve) state <= ST_MOVE;
                end
                ST_MOVE: begin
                    if (step_pulse) begin
                        dy_pos <= dy_nxt;
                        if (score_for_l || score_for_r) begin
                            ball_x   <= X_CTR;
                            ball_y   <= Y_CTR;
                            hold_cnt <= HOLD_W'(SCORE_HOLD);
                            // The ball is served back toward whoever conceded.
                            dx_pos   <= score_for_l;
                            if (score_for_l) begin
                                point_l <= 1'b1;
                                score_l <= score_l_inc;
                                state   <= (score_l_inc == WIN) ? ST_OVER : ST_SCORED;
                            end else begin
                                point_r <= 1'b1;
                                score_r <= score_r_inc;
                                state   <= (score_r_inc == WIN) ? ST_OVER : ST_SCORED;
                            end
                        end else begin
                            ball_x <= x_nxt;
                            ball_y <= y_nxt;
                            dx_pos <= dx_nxt;
                        end
                    end
                end
                ST_SCORED: begin
                    if (step_pulse) begin
                        if (hold_cnt <= HOLD_W'(1)) begin
                            hold_cnt <= '0;
                            state    <= ST_MOVE;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                end
                ST_OVER: begin
                    if (serve) begin
                        score_l <= 4'd0;
                        score_r <= 4'd0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BALL_SPEEDUP_EN
    // Speed ramps with each paddle return and drops back to 1 after a point.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            speed <= 3'd1;
        end else if ((state == ST_MOVE) && step_pulse) begin
            if (score_for_l || score_for_r) begin
                speed <= 3'd1;
            end else if (hit && (speed < 3'd4)) begin
                speed <= speed + 3'd1;
            end
        end
    end
`else
    // Fixed speed; paddle hits then only affect direction.
    logic hit_unused;
    assign hit_unused = hit;
    assign speed      = 3'd1;
`endif

    // OVER is the only state that flags the end of the game.
    always_comb game_over = (state == ST_OVER);

endmodule
